// File: rtl/recirc_mem_pkg.sv
// rtl/recirc_mem_pkg.sv - shared FSM encoding and ring depth helper for recirc_shift_mem
package recirc_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    function automatic int unsigned depth_of(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/word_ring.sv
// rtl/word_ring.sv - recirculating shift ring; stage 0 is the head, optional write-back at the tail
module word_ring
    import recirc_mem_pkg::*;
#(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic [DATA_BITS-1:0] head_data
);

    localparam int D = depth_of(ADDR_BITS);

    logic [DATA_BITS-1:0] stage_q [D];
    logic [DATA_BITS-1:0] stage_d [D];

    // Rotate one step toward the head; the head word re-enters at the tail unless replaced.
    always_comb begin
        for (int i = 0; i < D - 1; i++) begin
            stage_d[i] = stage_q[i + 1];
        end
        stage_d[D - 1] = wr_en ? wr_data : stage_q[0];
    end

    // Ring storage; reset clears every stage and suppresses rotation for that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head_data = stage_q[0];

endmodule

// File: rtl/recirc_shift_mem.sv
// rtl/recirc_shift_mem.sv - request FSM, address latch, head counter and response register around word_ring
module recirc_shift_mem
    import recirc_mem_pkg::*;
#(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic [ADDR_BITS-1:0] head_addr
);

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [ADDR_BITS-1:0] head_q, head_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                 hit;
    logic                 ring_wr_en;
    logic [DATA_BITS-1:0] ring_head;

    word_ring #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (ring_wr_en),
        .wr_data   (wdata_q),
        .head_data (ring_head)
    );

    // A write hit swaps: the old head word goes to the response, the latched data re-enters the ring.
    assign ring_wr_en = hit && we_q;

    // Next-state: accept in IDLE, wait for the target word to reach the head, then respond.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        head_d      = head_q + 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        hit         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (head_q == addr_q) begin
                    hit         = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ring_head;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            head_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            head_q      <= head_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign head_addr = head_q;

endmodule

// File: tb/tb_recirc_shift_mem.sv
// tb/tb_recirc_shift_mem.sv - scoreboard bench for recirc_shift_mem against a word-array reference model
module tb_recirc_shift_mem;

    localparam int AB = 5;
    localparam int DB = 8;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [DB-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DB-1:0] rsp_rdata;
    logic [AB-1:0] head_addr;

    recirc_shift_mem #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .head_addr (head_addr)
    );

    typedef struct {
        int            cyc;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DB-1:0] mem [D];
    logic [DB-1:0] last_rdata = '0;
    int            cyc = 0;
    int            acc_cyc = -10;
    int            resp_cyc = -10;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the model timeline and the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic exp_valid;
            logic exp_ready;
            exp_ready = !(cyc > acc_cyc && cyc < resp_cyc);
            check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            check("head_addr", {27'd0, head_addr}, cyc % D);
            while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            exp_valid = (sb.size() > 0 && sb[0].cyc == cyc);
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_valid) check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
                last_rdata = e.data;
            end else if (!rsp_valid) begin
                check("rsp_rdata_hold", {24'd0, rsp_rdata}, {24'd0, last_rdata});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < D; i++) mem[i] = '0;
        last_rdata = '0;
        acc_cyc = -10;
        resp_cyc = -10;
        repeat (3) step();
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Offer a request in the current cycle (DUT assumed idle); model predicts response cycle and data.
    task automatic issue(input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d,
                         input bit wait_rsp, input bit noise);
        int p;
        int k;
        int rc;
        p  = cyc % D;
        k  = ((int'(a) - p - 1 + 2 * D) % D) + 1;
        rc = cyc + k + 1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        sb.push_back(exp_t'{cyc: rc, data: mem[a]});
        if (we) mem[a] = d;
        acc_cyc  = cyc;
        resp_cyc = rc;
        step();
        if (wait_rsp) begin
            while (cyc < rc) begin
                if (noise) begin
                    req_valid = 1'b1;
                    req_we    = 1'($urandom);
                    req_addr  = AB'($urandom);
                    req_wdata = DB'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
                step();
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_head(input int h);
        for (int i = 0; i < D && (cyc % D) != h; i++) step();
    endtask

    initial begin
        do_reset();

        // Write then swap/read sequence on address 5, first request offered at cycle 0.
        issue(1'b1, 5'd5, 8'hA5, 1'b1, 1'b0);
        issue(1'b0, 5'd5, 8'h00, 1'b1, 1'b0);
        issue(1'b1, 5'd5, 8'h3C, 1'b1, 1'b0);
        issue(1'b0, 5'd5, 8'h00, 1'b1, 1'b0);

        // Latency extremes and head wrap.
        issue(1'b0, AB'(cyc % D), 8'h00, 1'b1, 1'b0);
        issue(1'b0, AB'((cyc + 1) % D), 8'h00, 1'b1, 1'b0);
        wait_head(31);
        issue(1'b1, 5'd0, 8'hE1, 1'b1, 1'b0);

        // Fill every address back-to-back, then read all of them back.
        for (int i = 0; i < D; i++) issue(1'b1, AB'(i), DB'(i) ^ 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < D; i++) issue(1'b0, AB'(i), 8'h00, 1'b1, 1'b0);

        // Request lines churn while the DUT waits.
        for (int i = 0; i < 6; i++) issue(1'($urandom), AB'($urandom), DB'($urandom), 1'b1, 1'b1);

        // Random mix with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            issue(1'($urandom), AB'($urandom), DB'($urandom), 1'b1, 1'($urandom));
        end

        // Reset in the middle of a long write wait to address 9.
        step();
        wait_head(9);
        issue(1'b1, 5'd9, 8'h77, 1'b0, 1'b0);
        step();
        step();
        do_reset();
        issue(1'b0, 5'd9, 8'h00, 1'b1, 1'b0);

        repeat (40) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recirc_shift_mem.md
RECIRC_SHIFT_MEM -- requirements
Module: recirc_shift_mem

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 5, the word address width; ring depth D = 2**ADDR_BITS.
REQ-002 SHALL have parameter DATA_BITS, default 8, the word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  a request is offered.
REQ-006 SHALL have port req_ready  output  1  a request can be accepted.
REQ-007 SHALL have port req_we  input  1  1 = write (swap), 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_BITS  target word address.
REQ-009 SHALL have port req_wdata  input  DATA_BITS  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  output  DATA_BITS  the target word's value before this access.
REQ-012 SHALL have port head_addr  output  ADDR_BITS  logical address currently at the ring head (debug).

Function
REQ-013 SHALL store D words in a recirculating shift ring; stage 0 is the head, holding the word at logical address head_addr.
REQ-014 SHALL, every non-reset cycle: shift stage[i] <= stage[i+1] for i < D-1; stage[D-1] <= stage[0], or req_wdata_q on a write hit; head_addr <= head_addr+1 mod D (D-1 wraps to 0).
REQ-015 SHALL implement a two-state FSM, IDLE and WAIT; req_ready = 1 exactly in IDLE.
REQ-016 SHALL accept a request when req_valid && req_ready; on acceptance it latches we, addr and wdata, then moves to WAIT. No hit is evaluated in the acceptance cycle.
REQ-017 SHALL declare a hit in a WAIT cycle where head_addr == latched addr.
REQ-018 SHALL, on a hit: register rsp_rdata <= stage[0]; assert rsp_valid for exactly the next cycle; return the FSM to IDLE for that same next cycle.
REQ-019 SHALL, for an accept at head_addr = p with addr a: place the hit k = ((a-p-1) mod D)+1 cycles later and assert rsp_valid at accept+k+1. The latency range is 2..D+1; a == p gives D+1 and a == p+1 gives 2.
REQ-020 SHALL treat a write as a swap: the new data enters the ring and rsp_rdata returns the old value.
REQ-021 SHALL ignore req_valid and all request fields while in WAIT; latched fields SHALL NOT change.
REQ-022 SHALL hold rsp_rdata between responses; rsp_valid SHALL be 0 except in response cycles.
REQ-023 SHALL allow back-to-back traffic: a new request may be accepted in the rsp_valid cycle, since req_ready is high then.

Reset
REQ-024 SHALL, while rst_n = 0 at a clock edge: set state IDLE, head_addr 0, rsp_valid 0, rsp_rdata 0, all ring stages 0; the ring SHALL NOT rotate.
REQ-025 SHALL abandon any in-flight request on reset: no rsp_valid and no write occur.
REQ-026 SHALL have head_addr = 0 and req_ready = 1 in the first cycle after rst_n rises.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, WAIT) and the depth-from-address-bits constant function in shared package recirc_mem_pkg.
REQ-028 SHALL isolate the storage ring in sub-module word_ring (ports: clk, rst_n, wr_en, wr_data, head_data), parametrised by ADDR_BITS and DATA_BITS.
REQ-029 SHALL keep the FSM, address latch, head counter and response register in recirc_shift_mem.

Verification (ADDR_BITS=5, DATA_BITS=8, D=32; cycle 0 = first cycle after reset release)
REQ-030 SHALL cover: write addr 5, data 0xA5, offered at cycle 0 -> rsp_valid only at cycle 6, rsp_rdata 0x00, req_ready low cycles 1-5.
REQ-031 SHALL cover: then read addr 5 -> rsp_rdata 0xA5; write addr 5, data 0x3C -> rsp_rdata 0xA5; a further read returns 0x3C.
REQ-032 SHALL cover latency bounds: a request with addr == head_addr -> rsp 33 cycles later; with addr == head_addr+1 -> rsp 2 cycles later; also addr 0 accepted when head_addr = 31 (wrap).
REQ-033 SHALL cover: write addr i with data i^0x5A for all 32 addresses back-to-back, then read all 32 -> every read matches; no accept occurs while req_ready = 0.
REQ-034 SHALL cover: req_valid held high with changing addr/wdata during WAIT -> response reflects only the latched request.
REQ-035 SHALL cover: assert rst_n = 0 mid-WAIT of a write to addr 9 -> no rsp_valid; afterwards head_addr = 0 and a read of addr 9 returns 0x00.
